mii_tx_framer: RTL
==================

MII_TX_FRAMER -- requirements
Module: mii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_NIBBLES, default 24, meaning inter-frame gap length in clock cycles (24 nibbles = 12 bytes).
REQ-002 SHALL have port clock  input  1  MII TX clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port saxis_tdata  input  8  frame byte (FCS already appended upstream).
REQ-005 SHALL have port saxis_tvalid  input  1  byte valid.
REQ-006 SHALL have port saxis_tready  output  1  byte accepted when tvalid&tready at a rising edge.
REQ-007 SHALL have port saxis_tlast  input  1  last byte of frame.
REQ-008 SHALL have port saxis_tuser  input  1  on the tlast byte only: frame error flag.
REQ-009 SHALL have port mii_tx_en  output  1  MII transmit enable, registered.
REQ-010 SHALL have port mii_txd  output  4  MII transmit nibble, registered.
REQ-011 SHALL have port mii_tx_er  output  1  MII transmit error, registered.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, DATA, DISCARD, IFG.
REQ-013 IDLE: tx_en=0, txd=0, tx_er=0, tready=0; when tvalid=1 is sampled, SHALL enter PREAMBLE without consuming the byte.
REQ-014 PREAMBLE SHALL last exactly 16 cycles with tx_en=1: txd=0x5 for preamble nibbles 0..14 and txd=0xD for nibble 15 (SFD 0xD5, low nibble first).
REQ-015 tready SHALL be combinational and equal 1 only in: PREAMBLE nibble 15; DATA high-nibble cycle when the held byte is not last; DISCARD.
REQ-016 On each tready=1 edge in PREAMBLE/DATA with tvalid=1, SHALL capture tdata, tlast, tuser; the next two cycles output txd=tdata[3:0] then txd=tdata[7:4] with tx_en=1, giving back-to-back bytes with no gap.
REQ-017 tx_er SHALL be 1 during both nibbles of a captured byte whose tlast=1 and tuser=1; otherwise 0 in DATA.
REQ-018 After the high nibble of a tlast byte, SHALL enter IFG: tx_en=0, txd=0, tready=0 for IFG_NIBBLES cycles, then IDLE; tvalid during IFG SHALL be ignored.
REQ-019 Underrun: if tvalid=0 on a tready=1 edge in PREAMBLE or DATA, the next cycle SHALL drive tx_en=1, tx_er=1, txd=0 for one cycle, then enter DISCARD.
REQ-020 DISCARD: tx_en=0, tready=1; bytes SHALL be dropped until a tlast handshake, then enter IFG.
REQ-021 Latency: tvalid first sampled high at edge k in IDLE -> tx_en=1 from edge k; first data low nibble from edge k+16; a frame of N bytes occupies 16+2N tx_en cycles.
REQ-022 A 1-byte frame SHALL be legal (tlast captured at PREAMBLE nibble 15).
REQ-023 Preamble and IFG counters SHALL not wrap beyond their terminal counts; IFG_NIBBLES=0 SHALL return to IDLE the cycle after the last nibble.

Reset
REQ-024 aresetn=0 SHALL immediately force state IDLE, counters 0, tx_en=0, txd=0, tx_er=0, tready=0, including mid-frame; no partial frame SHALL resume after release.
REQ-025 The first tvalid after reset release SHALL start a full 16-nibble preamble.

Verification
REQ-026 Bytes 0x12,0x34 (tlast on 0x34, tuser=0), tvalid held -> txd 5x15, D, 2,1,4,3, tx_en high 20 cycles, tx_er=0, then 24 idle cycles.
REQ-027 1-byte frame 0xA5 tuser=1 -> after preamble/SFD, txd 5 then A with tx_er=1 on both, tx_en=1.
REQ-028 Two frames back-to-back with tvalid continuous -> exactly IFG_NIBBLES cycles of tx_en=0 between them, second starts with 0x5 preamble.
REQ-029 tvalid dropped before the 3rd byte of a 5-byte frame -> one cycle tx_en=1,tx_er=1, then tx_en=0; remaining bytes consumed through tlast; IFG follows.
REQ-030 aresetn pulsed low during DATA -> all outputs 0 asynchronously; after release and new tvalid, fresh preamble of 16 nibbles.
REQ-031 Randomised 100 frames of 1-24 bytes with random tvalid gaps between frames only -> nibble stream reassembles exactly to input bytes, tx_er only on tuser-flagged last bytes.

Source files
------------

// File: rtl/mii_tx_framer.sv
// MII transmit framer: turns an AXI-Stream byte stream into preamble/SFD, nibble
// data (low nibble first) and an inter-frame gap, with underrun and error signalling.
module mii_tx_framer #(
    parameter int IFG_NIBBLES = 24
) (
    input  logic       clock,
    input  logic       aresetn,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    input  logic       saxis_tuser,
    output logic       mii_tx_en,
    output logic [3:0] mii_txd,
    output logic       mii_tx_er
);

    localparam int CW = $clog2((IFG_NIBBLES > 16 ? IFG_NIBBLES : 16) + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(15);
    localparam logic [CW-1:0] PRE_SFD  = CW'(14);
    // The IDLE cycle that samples tvalid is the final gap nibble, so the IFG
    // state itself runs one cycle short of IFG_NIBBLES.
    localparam logic [CW-1:0] IFG_LAST = (IFG_NIBBLES >= 2) ? CW'(IFG_NIBBLES - 2) : '0;
    localparam bit            IFG_SKIP = (IFG_NIBBLES <= 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DISCARD,
        ST_IFG
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    data_q;
    logic          last_q;
    logic          user_q;
    logic          phase_q;
    logic          underrun_q;
    logic          tx_en_q;
    logic [3:0]    txd_q;
    logic          tx_er_q;

    logic pre_slot;
    logic data_slot;

    assign pre_slot     = (state_q == ST_PREAMBLE) && (cnt_q == PRE_LAST);
    assign data_slot    = (state_q == ST_DATA) && phase_q && !last_q && !underrun_q;
    assign saxis_tready = pre_slot || data_slot || (state_q == ST_DISCARD);

    assign mii_tx_en = tx_en_q;
    assign mii_txd   = txd_q;
    assign mii_tx_er = tx_er_q;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            user_q     <= 1'b0;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
            tx_en_q    <= 1'b0;
            txd_q      <= '0;
            tx_er_q    <= 1'b0;
        end else if (pre_slot || data_slot) begin
            // Byte slot: either start the next byte or flag an underrun nibble.
            state_q <= ST_DATA;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            tx_en_q <= 1'b1;
            if (saxis_tvalid) begin
                data_q  <= saxis_tdata;
                last_q  <= saxis_tlast;
                user_q  <= saxis_tuser;
                txd_q   <= saxis_tdata[3:0];
                tx_er_q <= saxis_tlast & saxis_tuser;
            end else begin
                underrun_q <= 1'b1;
                txd_q      <= 4'h0;
                tx_er_q    <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q   <= '0;
                    tx_er_q <= 1'b0;
                    if (saxis_tvalid) begin
                        state_q <= ST_PREAMBLE;
                        tx_en_q <= 1'b1;
                        txd_q   <= 4'h5;
                    end else begin
                        tx_en_q <= 1'b0;
                        txd_q   <= 4'h0;
                    end
                end
                ST_PREAMBLE: begin
                    cnt_q   <= cnt_q + 1'b1;
                    tx_en_q <= 1'b1;
                    tx_er_q <= 1'b0;
                    txd_q   <= (cnt_q == PRE_SFD) ? 4'hD : 4'h5;
                end
                ST_DATA: begin
                    if (underrun_q) begin
                        state_q    <= ST_DISCARD;
                        underrun_q <= 1'b0;
                        tx_en_q    <= 1'b0;
                        txd_q      <= 4'h0;
                        tx_er_q    <= 1'b0;
                    end else if (!phase_q) begin
                        phase_q <= 1'b1;
                        txd_q   <= data_q[7:4];
                    end else begin
                        state_q <= IFG_SKIP ? ST_IDLE : ST_IFG;
                        cnt_q   <= '0;
                        phase_q <= 1'b0;
                        last_q  <= 1'b0;
                        tx_en_q <= 1'b0;
                        txd_q   <= 4'h0;
                        tx_er_q <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= 4'h0;
                    tx_er_q <= 1'b0;
                    if (saxis_tvalid && saxis_tlast) begin
                        state_q <= IFG_SKIP ? ST_IDLE : ST_IFG;
                        cnt_q   <= '0;
                    end
                end
                ST_IFG: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= 4'h0;
                    tx_er_q <= 1'b0;
                    if (cnt_q == IFG_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    tx_en_q <= 1'b0;
                    txd_q   <= 4'h0;
                    tx_er_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
